// File: rtl/apb_master_ctrl.sv
// APB master bridging a valid/ready request channel onto two APB slaves.
// Address-decoded slave select, bounded ACCESS wait, registered response channel.
module apb_master_ctrl #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic                  req_write_i,
    input  logic [DATA_WIDTH-1:0] req_wdata_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [DATA_WIDTH-1:0] rsp_rdata_o,
    output logic                  rsp_err_o,
    output logic [1:0]            psel_o,
    output logic                  penable_o,
    output logic [ADDR_WIDTH-1:0] paddr_o,
    output logic                  pwrite_o,
    output logic [DATA_WIDTH-1:0] pwdata_o,
    input  logic [1:0]            pready_i,
    input  logic [1:0]            pslverr_i,
    input  logic [DATA_WIDTH-1:0] prdata1_i,
    input  logic [DATA_WIDTH-1:0] prdata2_i
);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } state_t;

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t                state, state_nxt;
    logic [CNT_W-1:0]      wait_cnt, wait_cnt_nxt;
    logic                  req_ready_nxt;
    logic                  rsp_valid_nxt;
    logic [DATA_WIDTH-1:0] rsp_rdata_nxt;
    logic                  rsp_err_nxt;
    logic [1:0]            psel_nxt;
    logic                  penable_nxt;
    logic [ADDR_WIDTH-1:0] paddr_nxt;
    logic                  pwrite_nxt;
    logic [DATA_WIDTH-1:0] pwdata_nxt;

    logic                  hit1, hit2;
    logic                  sel_ready, sel_err;
    logic [DATA_WIDTH-1:0] sel_rdata;

    // Each slave owns one 4 KiB page, so only the page number is compared.
    always_comb begin
        hit1 = (req_addr_i[ADDR_WIDTH-1:12] == (ADDR_WIDTH-12)'(32'h1F));
        hit2 = (req_addr_i[ADDR_WIDTH-1:12] == (ADDR_WIDTH-12)'(32'h2F));
    end

    // Masking with the registered one-hot select keeps the idle slave's inputs out.
    always_comb begin
        sel_ready = |(pready_i & psel_o);
        sel_err   = |(pslverr_i & psel_o);
        sel_rdata = psel_o[1] ? prdata2_i : prdata1_i;
    end

    always_comb begin
        state_nxt     = state;
        wait_cnt_nxt  = wait_cnt;
        req_ready_nxt = req_ready_o;
        rsp_valid_nxt = rsp_valid_o;
        rsp_rdata_nxt = rsp_rdata_o;
        rsp_err_nxt   = rsp_err_o;
        psel_nxt      = psel_o;
        penable_nxt   = penable_o;
        paddr_nxt     = paddr_o;
        pwrite_nxt    = pwrite_o;
        pwdata_nxt    = pwdata_o;

        case (state)
            IDLE: begin
                if (req_valid_i) begin
                    req_ready_nxt = 1'b0;
                    if (hit1 || hit2) begin
                        state_nxt    = SETUP;
                        psel_nxt     = {hit2, hit1};
                        penable_nxt  = 1'b0;
                        paddr_nxt    = req_addr_i;
                        pwrite_nxt   = req_write_i;
                        pwdata_nxt   = req_wdata_i;
                        wait_cnt_nxt = '0;
                    end else begin
                        state_nxt     = RESP;
                        rsp_valid_nxt = 1'b1;
                        rsp_err_nxt   = 1'b1;
                        rsp_rdata_nxt = '0;
                    end
                end
            end

            SETUP: begin
                state_nxt   = ACCESS;
                penable_nxt = 1'b1;
            end

            ACCESS: begin
                if (sel_ready) begin
                    state_nxt     = RESP;
                    psel_nxt      = '0;
                    penable_nxt   = 1'b0;
                    rsp_valid_nxt = 1'b1;
                    rsp_err_nxt   = sel_err;
                    rsp_rdata_nxt = pwrite_o ? '0 : sel_rdata;
                end else begin
                    wait_cnt_nxt = wait_cnt + CNT_W'(1);
                    // Counter reaches TIMEOUT on this cycle: abandon the slave.
                    if (wait_cnt == CNT_LAST) begin
                        state_nxt     = RESP;
                        psel_nxt      = '0;
                        penable_nxt   = 1'b0;
                        rsp_valid_nxt = 1'b1;
                        rsp_err_nxt   = 1'b1;
                        rsp_rdata_nxt = '0;
                    end
                end
            end

            RESP: begin
                if (rsp_ready_i) begin
                    state_nxt     = IDLE;
                    rsp_valid_nxt = 1'b0;
                    req_ready_nxt = 1'b1;
                end
            end

            default: begin
                state_nxt     = IDLE;
                req_ready_nxt = 1'b1;
                rsp_valid_nxt = 1'b0;
                psel_nxt      = '0;
                penable_nxt   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            req_ready_o <= 1'b1;
            rsp_valid_o <= 1'b0;
            rsp_rdata_o <= '0;
            rsp_err_o   <= 1'b0;
            psel_o      <= '0;
            penable_o   <= 1'b0;
            paddr_o     <= '0;
            pwrite_o    <= 1'b0;
            pwdata_o    <= '0;
        end else begin
            state       <= state_nxt;
            wait_cnt    <= wait_cnt_nxt;
            req_ready_o <= req_ready_nxt;
            rsp_valid_o <= rsp_valid_nxt;
            rsp_rdata_o <= rsp_rdata_nxt;
            rsp_err_o   <= rsp_err_nxt;
            psel_o      <= psel_nxt;
            penable_o   <= penable_nxt;
            paddr_o     <= paddr_nxt;
            pwrite_o    <= pwrite_nxt;
            pwdata_o    <= pwdata_nxt;
        end
    end

endmodule

// File: tb/tb_apb_master_ctrl.sv
// Directed bench for apb_master_ctrl: cycle-exact checks of decode, wait states,
// timeout, error hold and asynchronous abort.
module tb_apb_master_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic [31:0] req_addr_i = '0;
    logic        req_write_i = 1'b0;
    logic [31:0] req_wdata_i = '0;
    logic        rsp_valid_o;
    logic        rsp_ready_i = 1'b0;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;
    logic [1:0]  psel_o;
    logic        penable_o;
    logic [31:0] paddr_o;
    logic        pwrite_o;
    logic [31:0] pwdata_o;
    logic [1:0]  pready_i = '0;
    logic [1:0]  pslverr_i = '0;
    logic [31:0] prdata1_i = '0;
    logic [31:0] prdata2_i = '0;

    int n_checks = 0;
    int n_fail = 0;

    apb_master_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_addr_i(req_addr_i), .req_write_i(req_write_i), .req_wdata_i(req_wdata_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
        .psel_o(psel_o), .penable_o(penable_o), .paddr_o(paddr_o),
        .pwrite_o(pwrite_o), .pwdata_o(pwdata_o),
        .pready_i(pready_i), .pslverr_i(pslverr_i),
        .prdata1_i(prdata1_i), .prdata2_i(prdata2_i)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] addr, input logic wr, input logic [31:0] wd);
        req_addr_i  = addr;
        req_write_i = wr;
        req_wdata_i = wd;
        req_valid_i = 1'b1;
        tick();
        req_valid_i = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (!req_ready_o && n < 60) begin
            tick();
            n++;
        end
        check(tag, {63'd0, req_ready_o}, 64'd1);
    endtask

    // Issue a read, check the decoded select one cycle later, then drain.
    task automatic probe(input logic [31:0] addr, input logic [1:0] exp_sel);
        pready_i    = 2'b11;
        pslverr_i   = 2'b00;
        rsp_ready_i = 1'b1;
        issue(addr, 1'b0, 32'h0);
        check($sformatf("probe_sel_%0h", addr), {62'd0, psel_o}, {62'd0, exp_sel});
        check($sformatf("probe_unmapped_rsp_%0h", addr), {63'd0, rsp_valid_o},
              {63'd0, (exp_sel == 2'b00)});
        wait_idle($sformatf("probe_drain_%0h", addr));
    endtask

    initial begin
        // Reset state
        #3;
        check("rst_psel", {62'd0, psel_o}, 64'd0);
        check("rst_penable", {63'd0, penable_o}, 64'd0);
        check("rst_paddr", {32'd0, paddr_o}, 64'd0);
        check("rst_pwdata", {32'd0, pwdata_o}, 64'd0);
        check("rst_rsp_valid", {63'd0, rsp_valid_o}, 64'd0);
        check("rst_rsp_rdata", {32'd0, rsp_rdata_o}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("rst_req_ready", {63'd0, req_ready_o}, 64'd1);

        // Read SLV1 0x0001_F004, ready first ACCESS; SLV2 inputs are decoys
        pready_i    = 2'b01;
        pslverr_i   = 2'b10;
        prdata1_i   = 32'hDEAD_BEEF;
        prdata2_i   = 32'h5555_AAAA;
        rsp_ready_i = 1'b1;
        issue(32'h0001_F004, 1'b0, 32'h0);
        check("rd1_t1_psel", {62'd0, psel_o}, 64'h1);
        check("rd1_t1_penable", {63'd0, penable_o}, 64'd0);
        check("rd1_t1_paddr", {32'd0, paddr_o}, 64'h0001_F004);
        check("rd1_t1_req_ready", {63'd0, req_ready_o}, 64'd0);
        tick();
        check("rd1_t2_psel", {62'd0, psel_o}, 64'h1);
        check("rd1_t2_penable", {63'd0, penable_o}, 64'd1);
        tick();
        check("rd1_t3_rsp_valid", {63'd0, rsp_valid_o}, 64'd1);
        check("rd1_t3_rdata", {32'd0, rsp_rdata_o}, 64'hDEAD_BEEF);
        check("rd1_t3_err", {63'd0, rsp_err_o}, 64'd0);
        check("rd1_t3_psel", {62'd0, psel_o}, 64'd0);
        tick();
        check("rd1_t4_req_ready", {63'd0, req_ready_o}, 64'd1);
        check("rd1_t4_rsp_valid", {63'd0, rsp_valid_o}, 64'd0);

        // Write SLV2 0x0002_FFFC, three wait states; SLV1 ready must be ignored
        pready_i  = 2'b01;
        pslverr_i = 2'b01;
        prdata2_i = 32'hCAFE_F00D;
        issue(32'h0002_FFFC, 1'b1, 32'h1234_5678);
        check("wr2_setup_psel", {62'd0, psel_o}, 64'h2);
        check("wr2_setup_pwrite", {63'd0, pwrite_o}, 64'd1);
        tick();
        for (int i = 0; i < 4; i++) begin
            check($sformatf("wr2_acc%0d_psel", i), {62'd0, psel_o}, 64'h2);
            check($sformatf("wr2_acc%0d_penable", i), {63'd0, penable_o}, 64'd1);
            check($sformatf("wr2_acc%0d_pwdata", i), {32'd0, pwdata_o}, 64'h1234_5678);
            if (i == 3) pready_i = 2'b11;
            tick();
        end
        check("wr2_rsp_valid", {63'd0, rsp_valid_o}, 64'd1);
        check("wr2_rsp_err", {63'd0, rsp_err_o}, 64'd0);
        check("wr2_rsp_rdata", {32'd0, rsp_rdata_o}, 64'd0);
        wait_idle("wr2_idle");

        // Unmapped read 0x0003_0000
        issue(32'h0003_0000, 1'b0, 32'h0);
        check("unm_psel", {62'd0, psel_o}, 64'd0);
        check("unm_rsp_valid", {63'd0, rsp_valid_o}, 64'd1);
        check("unm_err", {63'd0, rsp_err_o}, 64'd1);
        check("unm_rdata", {32'd0, rsp_rdata_o}, 64'd0);
        tick();
        check("unm_idle", {63'd0, req_ready_o}, 64'd1);

        // Address map boundaries
        probe(32'h0001_EFFF, 2'b00);
        probe(32'h0001_F000, 2'b01);
        probe(32'h0001_FFFF, 2'b01);
        probe(32'h0002_0000, 2'b00);
        probe(32'h0002_F000, 2'b10);
        probe(32'h0002_FFFF, 2'b10);

        // Timeout: SLV1 never ready
        pready_i  = 2'b10;
        pslverr_i = 2'b00;
        prdata1_i = 32'h0BAD_0BAD;
        issue(32'h0001_F100, 1'b0, 32'h0);
        tick();
        for (int i = 0; i < 15; i++) tick();
        check("to_acc16_psel", {62'd0, psel_o}, 64'h1);
        check("to_acc16_penable", {63'd0, penable_o}, 64'd1);
        tick();
        check("to_psel", {62'd0, psel_o}, 64'd0);
        check("to_penable", {63'd0, penable_o}, 64'd0);
        check("to_rsp_valid", {63'd0, rsp_valid_o}, 64'd1);
        check("to_err", {63'd0, rsp_err_o}, 64'd1);
        check("to_rdata", {32'd0, rsp_rdata_o}, 64'd0);
        wait_idle("to_idle");

        // SLV2 error response held while rsp_ready low
        pready_i    = 2'b10;
        pslverr_i   = 2'b10;
        prdata2_i   = 32'h7777_0001;
        rsp_ready_i = 1'b0;
        issue(32'h0002_F010, 1'b0, 32'h0);
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            check($sformatf("hold%0d_valid", i), {63'd0, rsp_valid_o}, 64'd1);
            check($sformatf("hold%0d_err", i), {63'd0, rsp_err_o}, 64'd1);
            check($sformatf("hold%0d_rdata", i), {32'd0, rsp_rdata_o}, 64'h7777_0001);
            check($sformatf("hold%0d_req_ready", i), {63'd0, req_ready_o}, 64'd0);
            pslverr_i = 2'b00;
            prdata2_i = 32'h0;
            tick();
        end
        check("hold_end_valid", {63'd0, rsp_valid_o}, 64'd1);
        rsp_ready_i = 1'b1;
        tick();
        check("hold_rel_valid", {63'd0, rsp_valid_o}, 64'd0);
        check("hold_rel_req_ready", {63'd0, req_ready_o}, 64'd1);

        // Asynchronous reset during ACCESS
        pready_i  = 2'b00;
        pslverr_i = 2'b00;
        issue(32'h0001_F200, 1'b0, 32'h0);
        tick();
        check("abort_pre_penable", {63'd0, penable_o}, 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_psel", {62'd0, psel_o}, 64'd0);
        check("abort_penable", {63'd0, penable_o}, 64'd0);
        check("abort_rsp_valid", {63'd0, rsp_valid_o}, 64'd0);
        pready_i = 2'b11;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("abort_post%0d_rsp_valid", i), {63'd0, rsp_valid_o}, 64'd0);
            check($sformatf("abort_post%0d_req_ready", i), {63'd0, req_ready_o}, 64'd1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/apb_master_ctrl.md
APB_MASTER_CTRL -- requirements
Module: apb_master_ctrl

Interface
REQ-001 Parameters SHALL be, one per line:
- ADDR_WIDTH, 32, request/APB address width
- DATA_WIDTH, 32, request/APB data width
- TIMEOUT, 16, maximum ACCESS cycles allowed without pready
REQ-002 Ports SHALL be, one per line:
- clk  input  1  single clock; all logic on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- req_valid_i  input  1  transfer request valid
- req_ready_o  output  1  request accepted when high with req_valid_i
- req_addr_i  input  ADDR_WIDTH  request address
- req_write_i  input  1  1=write, 0=read
- req_wdata_i  input  DATA_WIDTH  write data
- rsp_valid_o  output  1  response valid
- rsp_ready_i  input  1  response consumed
- rsp_rdata_o  output  DATA_WIDTH  read data
- rsp_err_o  output  1  error response
- psel_o  output  2  one-hot APB select; bit0=SLV1, bit1=SLV2
- penable_o  output  1  APB access phase
- paddr_o  output  ADDR_WIDTH  APB address
- pwrite_o  output  1  APB direction
- pwdata_o  output  DATA_WIDTH  APB write data
- pready_i  input  2  per-slave ready
- pslverr_i  input  2  per-slave error
- prdata1_i  input  DATA_WIDTH  SLV1 read data
- prdata2_i  input  DATA_WIDTH  SLV2 read data

Function
REQ-003 Address map SHALL be: SLV1 0x0001_F000-0x0001_FFFF, SLV2 0x0002_F000-0x0002_FFFF, inclusive; all other addresses unmapped.
REQ-004 FSM states SHALL be IDLE, SETUP, ACCESS, RESP; all outputs registered.
REQ-005 req_ready_o SHALL be 1 only in IDLE; a request is accepted on the cycle req_valid_i && req_ready_o.
REQ-006 Accepted mapped request: IDLE->SETUP next cycle; paddr_o/pwrite_o/pwdata_o loaded; psel_o set to decoded slave; penable_o=0.
REQ-007 SETUP->ACCESS unconditionally after one cycle; penable_o=1; psel_o, paddr_o, pwrite_o, pwdata_o held unchanged.
REQ-008 In ACCESS, only pready_i/pslverr_i/prdata of the selected slave SHALL be sampled; the other slave's inputs are ignored.
REQ-009 ACCESS with selected pready=1: capture rdata (read) or 0 (write), rsp_err_o=selected pslverr; next cycle state RESP, psel_o=0, penable_o=0, rsp_valid_o=1.
REQ-010 Wait counter SHALL clear on SETUP entry and increment each ACCESS cycle with pready=0; when it reaches TIMEOUT, transfer terminates: RESP next cycle, rsp_err_o=1, rsp_rdata_o=0, psel_o/penable_o=0.
REQ-011 Unmapped accepted request: IDLE->RESP next cycle, psel_o stays 0, rsp_err_o=1, rsp_rdata_o=0; no APB phase.
REQ-012 RESP SHALL hold rsp_valid_o, rsp_rdata_o, rsp_err_o stable until rsp_ready_i=1; then IDLE next cycle, rsp_valid_o=0.
REQ-013 Minimum mapped transaction (pready in first ACCESS cycle, rsp_ready_i=1): accept T, SETUP T+1, ACCESS T+2, rsp_valid T+3, req_ready_o=1 again T+4.
REQ-014 psel_o SHALL never have both bits set; penable_o=1 only when psel_o!=0.
REQ-015 pready_i/pslverr_i changes outside ACCESS SHALL have no effect.

Reset
REQ-016 rst_n=0 SHALL immediately (asynchronously) force state IDLE, psel_o=0, penable_o=0, paddr_o=0, pwrite_o=0, pwdata_o=0, rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0, counter=0; req_ready_o=1 after rst_n release.
REQ-017 Reset asserted mid-transfer SHALL abort it with no response generated.

Verification
REQ-018 Read 0x0001_F004, SLV1 pready=1 first ACCESS, prdata1=0xDEAD_BEEF -> psel_o=01 T+1..T+2, penable_o=1 T+2, rsp_rdata_o=0xDEAD_BEEF, rsp_err_o=0 at T+3.
REQ-019 Write 0x0002_FFFC data 0x1234_5678, SLV2 pready low 3 ACCESS cycles -> psel_o=10, pwdata_o stable all 4 ACCESS cycles, rsp_err_o=0, rsp_rdata_o=0.
REQ-020 Read 0x0003_0000 -> psel_o stays 00, rsp_valid_o=1 at T+1, rsp_err_o=1, rsp_rdata_o=0.
REQ-021 SLV1 pready held 0, TIMEOUT=16 -> after 16 ACCESS cycles psel_o/penable_o drop, rsp_err_o=1.
REQ-022 SLV2 pslverr=1 with pready=1, rsp_ready_i low 5 cycles -> rsp_valid_o/rsp_err_o=1 held 5 cycles, req_ready_o=0 until IDLE.
REQ-023 rst_n pulled low during ACCESS -> psel_o, penable_o, rsp_valid_o=0 same cycle; no response after release.
